// File: rtl/axi_ar_arb_pkg.sv
// Shared field widths and payload sizing for the AXI AR round-robin arbiter.
package axi_ar_arb_pkg;

    localparam int LEN_W    = 8;
    localparam int SIZE_W   = 3;
    localparam int BURST_W  = 2;
    localparam int CACHE_W  = 4;
    localparam int PROT_W   = 3;
    localparam int REGION_W = 4;
    localparam int QOS_W    = 4;

    function automatic int ar_payload_w(
        input int id_w,
        input int addr_w,
        input int user_w
    );
        return id_w + addr_w + user_w + LEN_W + SIZE_W + BURST_W + 1
             + CACHE_W + PROT_W + REGION_W + QOS_W;
    endfunction

endpackage

// File: rtl/axi_rr_arbiter_core.sv
// Combinational round-robin picker: first request at or after ptr, with wrap,
// found by scanning a doubled request vector whose low copy is masked below ptr.
module axi_rr_arbiter_core #(
    parameter int N     = 8,
    parameter int LOG_N = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [LOG_N-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [LOG_N-1:0] idx,
    output logic             any
);

    logic [2*N-1:0] keep;
    logic [2*N-1:0] dbl;

    always_comb begin
        keep = ~(((2*N)'(1) << ptr) - (2*N)'(1));
        dbl  = {req, req} & keep;
        idx  = '0;
        any  = 1'b0;
        // Descending scan so the lowest set position wins.
        for (int i = 2*N-1; i >= 0; i--) begin
            if (dbl[i]) begin
                idx = LOG_N'(i % N);
                any = 1'b1;
            end
        end
        gnt = '0;
        if (any) gnt[idx] = 1'b1;
    end

endmodule

// File: rtl/axi_ar_arbiter_rr.sv
// AR-channel round-robin merge with per-port outstanding limit and registered output.
// Optional QoS-priority masking is enabled by defining AXI_AR_QOS_PRIO_EN.
module axi_ar_arbiter_rr
    import axi_ar_arb_pkg::*;
#(
    parameter int AXI_ADDRESS_W = 32,
    parameter int AXI_USER_W    = 6,
    parameter int N_TARG_PORT   = 8,
    parameter int LOG_N_TARG    = $clog2(N_TARG_PORT),
    parameter int AXI_ID_IN     = 16,
    parameter int AXI_ID_OUT    = AXI_ID_IN + LOG_N_TARG,
    parameter int MAX_OUTST     = 4,
    parameter int CNT_W         = $clog2(MAX_OUTST + 1)
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [N_TARG_PORT-1:0][AXI_ID_IN-1:0]       arid_i,
    input  logic [N_TARG_PORT-1:0][AXI_ADDRESS_W-1:0]   araddr_i,
    input  logic [N_TARG_PORT-1:0][LEN_W-1:0]           arlen_i,
    input  logic [N_TARG_PORT-1:0][SIZE_W-1:0]          arsize_i,
    input  logic [N_TARG_PORT-1:0][BURST_W-1:0]         arburst_i,
    input  logic [N_TARG_PORT-1:0]                      arlock_i,
    input  logic [N_TARG_PORT-1:0][CACHE_W-1:0]         arcache_i,
    input  logic [N_TARG_PORT-1:0][PROT_W-1:0]          arprot_i,
    input  logic [N_TARG_PORT-1:0][REGION_W-1:0]        arregion_i,
    input  logic [N_TARG_PORT-1:0][AXI_USER_W-1:0]      aruser_i,
    input  logic [N_TARG_PORT-1:0][QOS_W-1:0]           arqos_i,
    input  logic [N_TARG_PORT-1:0]                      arvalid_i,
    output logic [N_TARG_PORT-1:0]                      arready_o,
    output logic [AXI_ID_OUT-1:0]                       arid_o,
    output logic [AXI_ADDRESS_W-1:0]                    araddr_o,
    output logic [LEN_W-1:0]                            arlen_o,
    output logic [SIZE_W-1:0]                           arsize_o,
    output logic [BURST_W-1:0]                          arburst_o,
    output logic                                        arlock_o,
    output logic [CACHE_W-1:0]                          arcache_o,
    output logic [PROT_W-1:0]                           arprot_o,
    output logic [REGION_W-1:0]                         arregion_o,
    output logic [AXI_USER_W-1:0]                       aruser_o,
    output logic [QOS_W-1:0]                            arqos_o,
    output logic                                        arvalid_o,
    input  logic                                        arready_i,
    input  logic                                        r_done_i,
    input  logic [AXI_ID_OUT-1:0]                       r_done_id_i
);

    localparam int PL_W = ar_payload_w(AXI_ID_OUT, AXI_ADDRESS_W, AXI_USER_W);

    logic [N_TARG_PORT-1:0][CNT_W-1:0] cnt;
    logic [N_TARG_PORT-1:0]            elig;
    logic [N_TARG_PORT-1:0]            req;
    logic [N_TARG_PORT-1:0]            gnt;
    logic [N_TARG_PORT-1:0]            inc;
    logic [N_TARG_PORT-1:0]            dec;
    logic [LOG_N_TARG-1:0]             rr_ptr;
    logic [LOG_N_TARG-1:0]             win;
    logic [LOG_N_TARG-1:0]             nxt_ptr;
    logic [LOG_N_TARG-1:0]             done_port;
    logic                              any;
    logic                              out_free;
    logic                              fire;
    logic                              done_hit;
    logic                              done_zero;
    logic [PL_W-1:0]                   pl_d;
    logic [PL_W-1:0]                   pl_q;
    logic                              unused_id_bits;

    assign done_port      = r_done_id_i[AXI_ID_OUT-1:AXI_ID_IN];
    assign unused_id_bits = ^r_done_id_i[AXI_ID_IN-1:0];

    always_comb begin
        for (int i = 0; i < N_TARG_PORT; i++) begin
            elig[i] = arvalid_i[i] && (cnt[i] < CNT_W'(MAX_OUTST));
        end
    end

`ifdef AXI_AR_QOS_PRIO_EN
    logic [QOS_W-1:0] qos_max;

    always_comb begin
        qos_max = '0;
        for (int i = 0; i < N_TARG_PORT; i++) begin
            if (elig[i] && arqos_i[i] > qos_max) qos_max = arqos_i[i];
        end
        for (int i = 0; i < N_TARG_PORT; i++) begin
            req[i] = elig[i] && (arqos_i[i] == qos_max);
        end
    end
`else
    assign req = elig;
`endif

    axi_rr_arbiter_core #(
        .N     (N_TARG_PORT),
        .LOG_N (LOG_N_TARG)
    ) u_core (
        .req (req),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (win),
        .any (any)
    );

    assign out_free  = !arvalid_o || arready_i;
    assign fire      = out_free && any;
    assign arready_o = fire ? gnt : '0;
    assign nxt_ptr   = (win == LOG_N_TARG'(N_TARG_PORT - 1)) ? '0 : win + 1'b1;

    assign pl_d = {win, arid_i[win], araddr_i[win], arlen_i[win],
                   arsize_i[win], arburst_i[win], arlock_i[win],
                   arcache_i[win], arprot_i[win], arregion_i[win],
                   aruser_i[win], arqos_i[win]};

    // Completions for an idle port or an out-of-range index are dropped.
    always_comb begin
        done_hit  = 1'b0;
        done_zero = 1'b0;
        for (int i = 0; i < N_TARG_PORT; i++) begin
            inc[i] = fire && gnt[i];
            dec[i] = 1'b0;
            if (done_port == LOG_N_TARG'(i)) begin
                done_hit  = 1'b1;
                done_zero = (cnt[i] == '0);
                dec[i]    = r_done_i && (cnt[i] != '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            rr_ptr    <= '0;
            arvalid_o <= 1'b0;
            pl_q      <= '0;
        end else begin
            for (int i = 0; i < N_TARG_PORT; i++) begin
                if (inc[i] && !dec[i]) cnt[i] <= cnt[i] + CNT_W'(1);
                else if (dec[i] && !inc[i]) cnt[i] <= cnt[i] - CNT_W'(1);
            end
            if (out_free) begin
                arvalid_o <= any;
                if (any) begin
                    pl_q   <= pl_d;
                    rr_ptr <= nxt_ptr;
                end
            end
        end
    end

    assign {arid_o, araddr_o, arlen_o, arsize_o, arburst_o, arlock_o,
            arcache_o, arprot_o, arregion_o, aruser_o, arqos_o} = pl_q;

    r_done_underflow: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(r_done_i && done_hit && done_zero)
    );

    r_done_port_range: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(r_done_i && !done_hit)
    );

endmodule

// File: tb/tb_axi_ar_arbiter_rr.sv
// Scoreboard bench for axi_ar_arbiter_rr (4 ports, 2 outstanding, 4-bit IDs).
module tb_axi_ar_arbiter_rr;

    localparam int N = 4;

    typedef struct packed {
        logic [5:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  region;
        logic [5:0]  user;
        logic [3:0]  qos;
    } ar_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [N-1:0][3:0]  s_arid;
    logic [N-1:0][31:0] s_araddr;
    logic [N-1:0][7:0]  s_arlen;
    logic [N-1:0][2:0]  s_arsize;
    logic [N-1:0][1:0]  s_arburst;
    logic [N-1:0]       s_arlock;
    logic [N-1:0][3:0]  s_arcache;
    logic [N-1:0][2:0]  s_arprot;
    logic [N-1:0][3:0]  s_arregion;
    logic [N-1:0][5:0]  s_aruser;
    logic [N-1:0][3:0]  s_arqos;
    logic [N-1:0]       s_arvalid = '0;
    logic [N-1:0]       s_arready;

    logic [5:0]  m_arid;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_arlock;
    logic [3:0]  m_arcache;
    logic [2:0]  m_arprot;
    logic [3:0]  m_arregion;
    logic [5:0]  m_aruser;
    logic [3:0]  m_arqos;
    logic        m_arvalid;
    logic        m_arready = 1'b1;
    logic        r_done = 1'b0;
    logic [5:0]  r_done_id = '0;

    ar_t cur [N];
    ar_t q [$];
    ar_t got_m;
    ar_t exp_m;
    int  tests = 0;
    int  fails = 0;

    axi_ar_arbiter_rr #(
        .N_TARG_PORT (N),
        .AXI_ID_IN   (4),
        .MAX_OUTST   (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .arid_i      (s_arid),
        .araddr_i    (s_araddr),
        .arlen_i     (s_arlen),
        .arsize_i    (s_arsize),
        .arburst_i   (s_arburst),
        .arlock_i    (s_arlock),
        .arcache_i   (s_arcache),
        .arprot_i    (s_arprot),
        .arregion_i  (s_arregion),
        .aruser_i    (s_aruser),
        .arqos_i     (s_arqos),
        .arvalid_i   (s_arvalid),
        .arready_o   (s_arready),
        .arid_o      (m_arid),
        .araddr_o    (m_araddr),
        .arlen_o     (m_arlen),
        .arsize_o    (m_arsize),
        .arburst_o   (m_arburst),
        .arlock_o    (m_arlock),
        .arcache_o   (m_arcache),
        .arprot_o    (m_arprot),
        .arregion_o  (m_arregion),
        .aruser_o    (m_aruser),
        .arqos_o     (m_arqos),
        .arvalid_o   (m_arvalid),
        .arready_i   (m_arready),
        .r_done_i    (r_done),
        .r_done_id_i (r_done_id)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit hit, want $finish");
        $fatal(1);
    end

    function automatic ar_t mk(input int p, input int seed, input logic [3:0] qos);
        ar_t a;
        a.id     = 6'((seed + p) & 15);
        a.addr   = 32'h1000_0000 + 32'(seed << 8) + 32'(p << 4);
        a.len    = 8'(seed + p);
        a.size   = 3'(p);
        a.burst  = 2'b01;
        a.lock   = 1'(p & 1);
        a.cache  = 4'h3;
        a.prot   = 3'(p);
        a.region = 4'(p + 1);
        a.user   = 6'(seed);
        a.qos    = qos;
        return a;
    endfunction

    function automatic ar_t expect_of(input int p);
        ar_t e;
        e    = cur[p];
        e.id = {2'(p), cur[p].id[3:0]};
        return e;
    endfunction

    function automatic ar_t out_now();
        return {m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock,
                m_arcache, m_arprot, m_arregion, m_aruser, m_arqos};
    endfunction

    task automatic drive();
        for (int p = 0; p < N; p++) begin
            s_arid[p]     = cur[p].id[3:0];
            s_araddr[p]   = cur[p].addr;
            s_arlen[p]    = cur[p].len;
            s_arsize[p]   = cur[p].size;
            s_arburst[p]  = cur[p].burst;
            s_arlock[p]   = cur[p].lock;
            s_arcache[p]  = cur[p].cache;
            s_arprot[p]   = cur[p].prot;
            s_arregion[p] = cur[p].region;
            s_aruser[p]   = cur[p].user;
            s_arqos[p]    = cur[p].qos;
        end
    endtask

    task automatic load(input int seed, input logic [3:0] qos);
        for (int p = 0; p < N; p++) cur[p] = mk(p, seed, qos);
        drive();
    endtask

    // Output-side scoreboard: every accepted master AR is popped and compared.
    always @(negedge clk) begin
        if (rst_n && m_arvalid && m_arready) begin
            got_m = out_now();
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL out_extra: got %h, want no transfer", got_m);
            end else begin
                exp_m = q.pop_front();
                if (got_m !== exp_m) begin
                    fails++;
                    $display("FAIL out_payload: got %h want %h", got_m, exp_m);
                end
            end
        end
    end

    task automatic cyc(input logic [N-1:0] exp, input string nm);
        @(negedge clk);
        #1;
        tests++;
        if (s_arready !== exp) begin
            fails++;
            $display("FAIL %s: arready_o=%b want %b", nm, s_arready, exp);
        end
        for (int p = 0; p < N; p++) if (exp[p]) q.push_back(expect_of(p));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [N-1:0] vld);
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        s_arvalid = vld;
        m_arready = 1'b1;
        r_done    = 1'b0;
        @(negedge clk);
        #1;
        tests++;
        if (m_arvalid !== 1'b0 || out_now() !== '0) begin
            fails++;
            $display("FAIL reset_out: arvalid_o=%b payload=%h want 0/0",
                     m_arvalid, out_now());
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic finish_test(input string nm);
        s_arvalid = '0;
        r_done    = 1'b0;
        m_arready = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: %0d outputs missing, want 0", nm, q.size());
        end
        q.delete();
    endtask

    task automatic test_reset();
        load(0, 4'h0);
        do_reset(4'hF);
        @(negedge clk);
        #1;
        tests++;
        if (s_arready !== 4'b0001) begin
            fails++;
            $display("FAIL reset_first_grant: arready_o=%b want 0001", s_arready);
        end
        s_arvalid = '0;
        @(posedge clk);
        #1;
        finish_test("reset");
    endtask

    task automatic test_round_robin();
        do_reset('0);
        load(1, 4'h2);
        s_arvalid = 4'hF;
        for (int k = 0; k < 5; k++) cyc(4'(1 << (k % 4)), "rr_grant");
        finish_test("rr");
    endtask

    task automatic test_outstanding();
        do_reset('0);
        load(2, 4'h0);
        s_arvalid = 4'b0010;
        cyc(4'b0010, "lim_first");
        cyc(4'b0010, "lim_second");
        cyc(4'b0000, "lim_block");
        r_done    = 1'b1;
        r_done_id = 6'b01_0000;
        cyc(4'b0000, "lim_done_cycle");
        r_done = 1'b0;
        cyc(4'b0010, "lim_release");
        finish_test("lim");
    endtask

    task automatic test_stall();
        ar_t held;
        do_reset('0);
        load(3, 4'h0);
        s_arvalid = 4'b1001;
        held = expect_of(0);
        cyc(4'b0001, "stall_pre");
        m_arready = 1'b0;
        load(4, 4'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            tests++;
            if (s_arready !== '0 || m_arvalid !== 1'b1 || out_now() !== held) begin
                fails++;
                $display("FAIL stall_hold: arready_o=%b arvalid_o=%b out=%h want 0000/1/%h",
                         s_arready, m_arvalid, out_now(), held);
            end
            @(posedge clk);
            #1;
        end
        m_arready = 1'b1;
        cyc(4'b1000, "stall_release");
        finish_test("stall");
    endtask

    task automatic test_same_cycle();
        do_reset('0);
        load(5, 4'h0);
        s_arvalid = 4'b0100;
        cyc(4'b0100, "sc_first");
        r_done    = 1'b1;
        r_done_id = 6'b10_0000;
        cyc(4'b0100, "sc_both");
        r_done = 1'b0;
        cyc(4'b0100, "sc_cnt_one");
        cyc(4'b0000, "sc_cnt_full");
        finish_test("sc");
    endtask

    task automatic test_qos();
        logic [N-1:0] first;
`ifdef AXI_AR_QOS_PRIO_EN
        first = 4'b0100;
`else
        first = 4'b0001;
`endif
        do_reset('0);
        load(6, 4'h0);
        cur[0].qos = 4'd1;
        cur[2].qos = 4'd4;
        drive();
        s_arvalid = 4'b0101;
        cyc(first, "qos_first");
        cyc(4'b0100, "qos_second");
        cyc(4'b0001, "qos_third");
        finish_test("qos");
    endtask

    initial begin
        load(0, 4'h0);
        test_reset();
        test_round_robin();
        test_outstanding();
        test_stall();
        test_same_cycle();
        test_qos();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
